dmem_arbiter: RTL and testbench

//  Shares the single-ported data memory between the processor core (load/store path) and a

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_if.sv | 24 ++
 rtl/dmem_arb_pick.sv | 45 ++++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (states, grant codes, access sizes).
package dmem_arb_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_DBG  = 2'd2
  } grant_e;

  // Access size/sign codes, identical to the encoding data_mem decodes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_arb_if.sv
// One requester port of the data-memory arbiter: valid/ready request plus one-cycle-later read return.
interface dmem_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        funct3;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata, funct3,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, funct3,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the data-memory arbiter.
// DMEM_ARB_RR_EN defined: OPEN-state ties alternate away from last_grant; otherwise core wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       core_valid,
  input  logic       dbg_valid,
  input  arb_state_e state,
  input  grant_e     last_grant,
  output grant_e     grant,
  output grant_e     last_grant_nxt
);

  always_comb begin
    grant = GNT_NONE;
    if (state == ARB_LOCKED) begin
      // The host owns the memory outright while locked.
      if (dbg_valid) begin
        grant = GNT_DBG;
      end
    end else if (core_valid && dbg_valid) begin
`ifdef DMEM_ARB_RR_EN
      if (last_grant == GNT_CORE) begin
        grant = GNT_DBG;
      end else begin
        grant = GNT_CORE;
      end
`else
      grant = GNT_CORE;
`endif
    end else if (core_valid) begin
      grant = GNT_CORE;
    end else if (dbg_valid) begin
      grant = GNT_DBG;
    end
  end

  always_comb begin
    last_grant_nxt = last_grant;
    if (grant != GNT_NONE) begin
      last_grant_nxt = grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core load/store path and the debug host,
// with a host lock bounded by a watchdog. Tie policy selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 256
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arb_if.slave         core,
  dmem_arb_if.slave         dbg,
  input  logic              dbg_lock,
  output logic              lock_timeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  grant_e           last_grant;
  grant_e           last_grant_nxt;
  grant_e           pick_grant;
  grant_e           grant;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic             lock_block;
  logic             lock_block_nxt;
  logic             lock_timeout_nxt;
  logic             core_load_c;
  logic             dbg_load_c;

  dmem_arb_pick u_pick (
    .core_valid     (core.valid),
    .dbg_valid      (dbg.valid),
    .state          (state),
    .last_grant     (last_grant),
    .grant          (pick_grant),
    .last_grant_nxt (last_grant_nxt)
  );

  // Nothing is accepted while reset is asserted.
  always_comb begin
    grant = GNT_NONE;
    if (reset) begin
      grant = pick_grant;
    end
  end

  assign core.ready  = (grant == GNT_CORE);
  assign dbg.ready   = (grant == GNT_DBG);
  assign core_load_c = (grant == GNT_CORE) && !core.we;
  assign dbg_load_c  = (grant == GNT_DBG) && !dbg.we;

  // Memory side follows the granted requester; idle bus is all zeros.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    case (grant)
      GNT_CORE: begin
        mem_we     = core.we;
        mem_addr   = core.addr;
        mem_wdata  = core.wdata;
        mem_funct3 = core.funct3;
      end
      GNT_DBG: begin
        mem_we     = dbg.we;
        mem_addr   = dbg.addr;
        mem_wdata  = dbg.wdata;
        mem_funct3 = dbg.funct3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ARB_OPEN;
      last_grant   <= GNT_DBG;
      lock_cnt     <= '0;
      lock_block   <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      lock_cnt     <= lock_cnt_nxt;
      lock_block   <= lock_block_nxt;
      lock_timeout <= lock_timeout_nxt;
    end
  end

  // Lock FSM; re-entry stays blocked after a forced release until dbg_lock is seen low.
  always_comb begin
    state_nxt        = state;
    lock_cnt_nxt     = lock_cnt;
    lock_block_nxt   = lock_block && dbg_lock;
    lock_timeout_nxt = lock_timeout;
    case (state)
      ARB_OPEN: begin
        lock_cnt_nxt = '0;
        if ((grant == GNT_DBG) && dbg_lock && !lock_block) begin
          state_nxt    = ARB_LOCKED;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      ARB_LOCKED: begin
        if (!dbg_lock) begin
          state_nxt    = ARB_OPEN;
          lock_cnt_nxt = '0;
        end else if (lock_cnt == CNT_W'(LOCK_MAX)) begin
          state_nxt        = ARB_OPEN;
          lock_cnt_nxt     = '0;
          lock_timeout_nxt = 1'b1;
          lock_block_nxt   = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = ARB_OPEN;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // Load data captured at the accept edge; rvalid pulses for exactly the following cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      core.rvalid <= 1'b0;
      core.rdata  <= '0;
      dbg.rvalid  <= 1'b0;
      dbg.rdata   <= '0;
    end else begin
      core.rvalid <= core_load_c;
      dbg.rvalid  <= dbg_load_c;
      if (core_load_c) begin
        core.rdata <= mem_rdata;
      end
      if (dbg_load_c) begin
        dbg.rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small memory, a transaction-level reference model checked every
// cycle, and literal expectations tagged onto specific cycles. Honours DMEM_ARB_RR_EN when defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LMAX = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dbg_lock = 1'b0;
  logic          lock_timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    mem_funct3;
  logic          mem_we;

  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) c_if ();
  dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) d_if ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .core         (c_if),
    .dbg          (d_if),
    .dbg_lock     (dbg_lock),
    .lock_timeout (lock_timeout),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_funct3   (mem_funct3),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] preload(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 9) return 32'hCAFEF00D;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (f3)
      3'b000: r[{off, 3'b000} +: 8] = d[7:0];
      3'b001: if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Stand-in for data_mem: combinational read, write at the clock edge.
  logic [31:0] dmem [0:63];
  bit          pre_done = 1'b0;
  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 64; i++) dmem[i] <= preload(i);
      pre_done <= 1'b1;
    end else if (mem_we) begin
      dmem[mem_addr[7:2]] <= st_merge(dmem[mem_addr[7:2]], mem_addr[1:0], mem_funct3, mem_wdata);
    end
  end
  assign mem_rdata = ld_ext(dmem[mem_addr[7:2]], mem_addr[1:0], mem_funct3);

  // Reference model state (what the outputs must be, per the arbitration rules).
  logic [31:0] ref_mem [0:63];
  bit          ref_init = 1'b0;
  bit          m_locked = 1'b0;
  bit          m_block = 1'b0;
  bit          m_tout = 1'b0;
  int          m_held = 0;
  int          m_last = 2;
  bit          m_rv_c = 1'b0;
  bit          m_rv_d = 1'b0;
  logic [31:0] m_rd_c = 32'h0;
  logic [31:0] m_rd_d = 32'h0;
  int          pin_id = 0;
  int          n_chk = 0;
  int          n_err = 0;

  int          g;
  bit          e_we;
  logic [31:0] e_addr;
  logic [31:0] e_wd;
  logic [2:0]  e_f3;
  logic [31:0] w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = preload(i);
      ref_init = 1'b1;
    end
    // Who owns the memory this cycle: 0 none, 1 core, 2 dbg.
    g = 0;
    if (reset) begin
      if (m_locked) begin
        if (d_if.valid) g = 2;
      end else if (c_if.valid && d_if.valid) begin
`ifdef DMEM_ARB_RR_EN
        g = (m_last == 1) ? 2 : 1;
`else
        g = 1;
`endif
      end else if (c_if.valid) begin
        g = 1;
      end else if (d_if.valid) begin
        g = 2;
      end
    end
    e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0; e_f3 = 3'b000;
    if (g == 1) begin
      e_we = c_if.we; e_addr = c_if.addr; e_wd = c_if.wdata; e_f3 = c_if.funct3;
    end else if (g == 2) begin
      e_we = d_if.we; e_addr = d_if.addr; e_wd = d_if.wdata; e_f3 = d_if.funct3;
    end

    chk("core_ready", 32'(c_if.ready), 32'(g == 1));
    chk("dbg_ready", 32'(d_if.ready), 32'(g == 2));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("mem_funct3", 32'(mem_funct3), 32'(e_f3));
    chk("core_rvalid", 32'(c_if.rvalid), 32'(m_rv_c));
    chk("core_rdata", c_if.rdata, m_rd_c);
    chk("dbg_rvalid", 32'(d_if.rvalid), 32'(m_rv_d));
    chk("dbg_rdata", d_if.rdata, m_rd_d);
    chk("lock_timeout", 32'(lock_timeout), 32'(m_tout));

    // Hand-computed expectations for tagged cycles.
    case (pin_id)
      1: begin
        chk("rst_core_ready", 32'(c_if.ready), 32'd0);
        chk("rst_dbg_ready", 32'(d_if.ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
      end
      2: begin
        chk("t1_core_ready", 32'(c_if.ready), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_funct3", 32'(mem_funct3), 32'd2);
      end
      3: begin
        chk("t1_core_rvalid", 32'(c_if.rvalid), 32'd1);
        chk("t1_core_rdata", c_if.rdata, 32'hDEADBEEF);
        chk("t1_dbg_rvalid", 32'(d_if.rvalid), 32'd0);
      end
      4: begin
        chk("t1_rvalid_pulse", 32'(c_if.rvalid), 32'd0);
        chk("t1_rdata_hold", c_if.rdata, 32'hDEADBEEF);
      end
      5: begin
        chk("dbg_load_rvalid", 32'(d_if.rvalid), 32'd1);
        chk("dbg_load_rdata", d_if.rdata, 32'hCAFEF00D);
      end
      6: begin
        chk("t2_first_core", 32'(c_if.ready), 32'd1);
        chk("t2_first_dbg", 32'(d_if.ready), 32'd0);
        chk("t2_mem_wdata", mem_wdata, 32'h1);
      end
      7: begin
`ifdef DMEM_ARB_RR_EN
        chk("t2_second_dbg", 32'(d_if.ready), 32'd1);
`else
        chk("t2_second_core", 32'(c_if.ready), 32'd1);
`endif
      end
      8: chk("t2_dbg_served", 32'(d_if.ready), 32'd1);
      9: chk("lock_core_blocked", 32'(c_if.ready), 32'd0);
      10: chk("unlock_core_first", 32'(c_if.ready), 32'd1);
      11: begin
        chk("t3_core_rvalid", 32'(c_if.rvalid), 32'd1);
        chk("t3_core_rdata", c_if.rdata, 32'h000000A0);
      end
      12: begin
        chk("t4_last_locked", 32'(c_if.ready), 32'd0);
        chk("t4_no_timeout_yet", 32'(lock_timeout), 32'd0);
      end
      13: begin
        chk("t4_core_after_force", 32'(c_if.ready), 32'd1);
        chk("t4_timeout_set", 32'(lock_timeout), 32'd1);
      end
      14: chk("t4_no_relock", 32'(c_if.ready), 32'd1);
      15: chk("t4_timeout_sticky", 32'(lock_timeout), 32'd1);
      16: begin
        chk("t5_rst_mem_we", 32'(mem_we), 32'd0);
        chk("t5_rst_core_ready", 32'(c_if.ready), 32'd0);
      end
      17: begin
        chk("t5_timeout_clr", 32'(lock_timeout), 32'd0);
        chk("t5_core_rvalid", 32'(c_if.rvalid), 32'd0);
        chk("t5_core_rdata", c_if.rdata, 32'h0);
        chk("t5_dbg_rdata", d_if.rdata, 32'h0);
        chk("t5_mem_unchanged", dmem[20], 32'h0);
      end
      18: begin
        chk("t6_sb_funct3", 32'(mem_funct3), 32'd0);
        chk("t6_sb_addr", mem_addr, 32'h41);
        chk("t6_sb_we", 32'(mem_we), 32'd1);
        chk("t6_sb_wdata", mem_wdata, 32'h33);
      end
      19: chk("t6_lbu_rdata", c_if.rdata, 32'h33);
      20: chk("lockrise_core_only", 32'(c_if.ready), 32'd1);
      21: begin
        chk("mem_0x20", dmem[8], 32'h1);
        chk("mem_0x30", dmem[12], 32'hA0);
        chk("mem_0x40", dmem[16], 32'h00803355);
      end
      default: ;
    endcase

    // Advance the model across the coming clock edge.
    if (!reset) begin
      m_locked = 1'b0; m_block = 1'b0; m_tout = 1'b0; m_held = 0; m_last = 2;
      m_rv_c = 1'b0; m_rv_d = 1'b0; m_rd_c = 32'h0; m_rd_d = 32'h0;
    end else begin
      m_rv_c = (g == 1) && !e_we;
      m_rv_d = (g == 2) && !e_we;
      if (g != 0) begin
        w = ref_mem[e_addr[7:2]];
        if (e_we) ref_mem[e_addr[7:2]] = st_merge(w, e_addr[1:0], e_f3, e_wd);
        else if (g == 1) m_rd_c = ld_ext(w, e_addr[1:0], e_f3);
        else m_rd_d = ld_ext(w, e_addr[1:0], e_f3);
        m_last = g;
      end
      if (!m_locked) begin
        if (g == 2 && dbg_lock && !m_block) begin
          m_locked = 1'b1;
          m_held = 1;
        end
      end else if (!dbg_lock) begin
        m_locked = 1'b0;
      end else if (m_held == int'(LMAX)) begin
        m_locked = 1'b0;
        m_tout = 1'b1;
        m_block = 1'b1;
      end else begin
        m_held++;
      end
      if (!dbg_lock) m_block = 1'b0;
    end
  end

  task automatic drv_c(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    c_if.valid = v; c_if.we = we; c_if.addr = a; c_if.wdata = d; c_if.funct3 = f3;
  endtask

  task automatic drv_d(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    d_if.valid = v; d_if.we = we; d_if.addr = a; d_if.wdata = d; d_if.funct3 = f3;
  endtask

  task automatic tick(input int p);
    pin_id = p;
    @(posedge clk);
    #1;
    pin_id = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drv_c(0, 0, 32'h0, 32'h0, F3_W);
    drv_d(0, 0, 32'h0, 32'h0, F3_W);
    @(posedge clk);
    #1;
    tick(1);
    tick(0);
    reset = 1'b1;

    // Core-only load
    drv_c(1, 0, 32'h10, 32'h0, F3_W); tick(2);
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(3);
    tick(4);
    // Host load, also leaves last grant with the host
    drv_d(1, 0, 32'h24, 32'h0, F3_W); tick(0);
    drv_d(0, 0, 32'h0, 32'h0, F3_W); tick(5);

    // Both valid for four cycles, then host alone
    drv_c(1, 1, 32'h20, 32'h1, F3_W);
    drv_d(1, 0, 32'h24, 32'h0, F3_W);
    tick(6); tick(7); tick(0); tick(0);
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(8);
    drv_d(0, 0, 32'h0, 32'h0, F3_W); tick(5);

    // Host lock with four stores, core waiting
    dbg_lock = 1'b1;
    drv_d(1, 1, 32'h30, 32'hA0, F3_W); tick(0);
    drv_c(1, 0, 32'h30, 32'h0, F3_W);
    for (int i = 1; i < 4; i++) begin
      drv_d(1, 1, 32'h30 + 32'(4 * i), 32'hA0 + 32'(i), F3_W);
      tick(9);
    end
    drv_d(0, 0, 32'h0, 32'h0, F3_W); tick(9); tick(9);
    dbg_lock = 1'b0; tick(9);
    tick(10);
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(11);

    // Watchdog forced release
    dbg_lock = 1'b1;
    drv_d(1, 0, 32'h10, 32'h0, F3_W); tick(0);
    drv_c(1, 0, 32'h20, 32'h0, F3_W);
    repeat (7) tick(9);
    tick(12);
    tick(13);
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(0); tick(0);
    drv_d(0, 0, 32'h0, 32'h0, F3_W);
    drv_c(1, 0, 32'h20, 32'h0, F3_W); tick(14);
    drv_c(0, 0, 32'h0, 32'h0, F3_W);
    dbg_lock = 1'b0; tick(0);
    dbg_lock = 1'b1;
    drv_d(1, 1, 32'h40, 32'h55, F3_W); tick(0);
    drv_d(0, 0, 32'h0, 32'h0, F3_W);
    drv_c(1, 0, 32'h20, 32'h0, F3_W); tick(9);
    dbg_lock = 1'b0; tick(9);
    tick(10);
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(15);

    // Reset while a core store is valid
    drv_c(1, 1, 32'h50, 32'h77, F3_W);
    reset = 1'b0; tick(16);
    reset = 1'b1;
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(17);

    // Byte store/load with address passthrough
    drv_c(1, 1, 32'h41, 32'h33, F3_B); tick(18);
    drv_c(1, 0, 32'h41, 32'h0, F3_BU); tick(0);
    drv_c(1, 1, 32'h42, 32'h80, F3_B); tick(19);
    drv_c(1, 0, 32'h42, 32'h0, F3_B); tick(0);
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(0);

    // Lock request while only the core is requesting
    dbg_lock = 1'b1;
    drv_c(1, 0, 32'h10, 32'h0, F3_W); tick(20); tick(20);
    dbg_lock = 1'b0;
    drv_c(0, 0, 32'h0, 32'h0, F3_W); tick(21);
    tick(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
